// File: rtl/sdf_bitrev_reorder_if.sv
// sdf_bitrev_reorder_if: sample stream bus; master drives in_valid/data_in_r/data_in_i, slave drives out_valid/data_out_r/data_out_i/out_first/out_last
interface sdf_bitrev_reorder_if #(parameter int DATA_WIDTH = 16);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] data_in_r;
  logic [DATA_WIDTH-1:0] data_in_i;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] data_out_r;
  logic [DATA_WIDTH-1:0] data_out_i;
  logic                  out_first;
  logic                  out_last;
  modport master (
    output in_valid, data_in_r, data_in_i,
    input  out_valid, data_out_r, data_out_i, out_first, out_last
  );
  modport slave (
    input  in_valid, data_in_r, data_in_i,
    output out_valid, data_out_r, data_out_i, out_first, out_last
  );
endinterface

// File: rtl/sdf_bitrev_reorder.sv
// sdf_bitrev_reorder: ping-pong bit-reversed to natural order reorder buffer; ports clk, rst (async high), bus (slave: in_valid/data_in_* in, out_valid/data_out_*/out_first/out_last out)
module sdf_bitrev_reorder #(
  parameter int N_POINTS   = 128,
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 16
) (
  input logic clk,
  input logic rst,
  sdf_bitrev_reorder_if.slave bus
);
  typedef enum logic {IDLE, READ} state_t;
  state_t state, state_nxt;
  logic [ADDR_WIDTH-1:0] wr_cnt, rd_cnt, wr_addr;
  logic wr_bank, rd_bank, wr_last, rd_en, rd_last;
  logic [1:0] full, full_set, full_clr;
  logic [2*DATA_WIDTH-1:0] mem [2*N_POINTS];
  for (genvar i = 0; i < ADDR_WIDTH; i++) begin : g_rev
    assign wr_addr[i] = wr_cnt[ADDR_WIDTH-1-i];
  end
  assign wr_last  = bus.in_valid && wr_cnt == ADDR_WIDTH'(N_POINTS-1);
  assign full_set = wr_last ? 2'(2'b01 << wr_bank) : 2'b00;
  always_ff @(posedge clk) begin
    if (bus.in_valid) mem[{wr_bank, wr_addr}] <= {bus.data_in_r, bus.data_in_i};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
      full    <= 2'b00;
    end else begin
      if (bus.in_valid) wr_cnt <= wr_cnt + 1'b1;
      if (wr_last) wr_bank <= ~wr_bank;
      full <= (full & ~full_clr) | full_set;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = (state == IDLE) ? (full[rd_bank] ? READ : IDLE)
                                : ((rd_last && !full[~rd_bank]) ? IDLE : READ);
  end
  always_comb begin
    rd_en    = state == READ;
    rd_last  = rd_en && rd_cnt == ADDR_WIDTH'(N_POINTS-1);
    full_clr = rd_last ? 2'(2'b01 << rd_bank) : 2'b00;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt         <= '0;
      rd_bank        <= 1'b0;
      bus.out_valid  <= 1'b0;
      bus.out_first  <= 1'b0;
      bus.out_last   <= 1'b0;
      bus.data_out_r <= '0;
      bus.data_out_i <= '0;
    end else begin
      rd_cnt        <= rd_en ? rd_cnt + 1'b1 : '0;
      if (rd_last) rd_bank <= ~rd_bank;
      bus.out_valid <= rd_en;
      bus.out_first <= rd_en && rd_cnt == '0;
      bus.out_last  <= rd_last;
      if (rd_en) {bus.data_out_r, bus.data_out_i} <= mem[{rd_bank, rd_cnt}];
    end
  end
endmodule

// File: tb/tb_sdf_bitrev_reorder.sv
// tb_sdf_bitrev_reorder: directed bench with a frame-level reorder model checked every cycle
module tb_sdf_bitrev_reorder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sdf_bitrev_reorder_if #(.DATA_WIDTH(16)) if8 ();
  sdf_bitrev_reorder_if #(.DATA_WIDTH(16)) if128 ();

  sdf_bitrev_reorder #(.N_POINTS(8), .ADDR_WIDTH(3), .DATA_WIDTH(16)) dut8 (
    .clk(clk), .rst(rst), .bus(if8)
  );
  sdf_bitrev_reorder #(.N_POINTS(128), .ADDR_WIDTH(7), .DATA_WIDTH(16)) dut128 (
    .clk(clk), .rst(rst), .bus(if128)
  );

  typedef struct {int r; int i; bit f; bit l; int due;} exp_t;
  localparam int PERM8 [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  localparam int NPTS [2] = '{8, 128};
  localparam int AW   [2] = '{3, 7};

  exp_t q0[$], q1[$];
  int pr [2][128];
  int pi [2][128];
  int pc [2];
  int edge_n;
  int last_cap [2];
  int first_edge [2];
  int log_r [2][256];
  int log_i [2][256];
  bit log_f [2][256];
  bit log_l [2][256];
  int log_n [2];
  int run [2];
  int maxrun [2];
  int checks;
  int errors;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int brev(input int v, input int w);
    int r = 0;
    for (int b = 0; b < w; b++) r |= ((v >> b) & 1) << (w - 1 - b);
    return r;
  endfunction

  // Input position j holds natural index brev(j), so natural output k is input position brev(k).
  task automatic cap(input int c, input bit v, input int r, input int i);
    exp_t e;
    if (!v) return;
    pr[c][pc[c]] = r;
    pi[c][pc[c]] = i;
    pc[c]++;
    if (pc[c] == NPTS[c]) begin
      pc[c] = 0;
      last_cap[c] = edge_n;
      for (int k = 0; k < NPTS[c]; k++) begin
        e.r = pr[c][brev(k, AW[c])];
        e.i = pi[c][brev(k, AW[c])];
        e.f = k == 0;
        e.l = k == NPTS[c] - 1;
        e.due = edge_n + 2 + k;
        if (c == 0) q0.push_back(e);
        else q1.push_back(e);
      end
    end
  endtask

  task automatic cmp(input int c, input bit v, input int r, input int i, input bit f, input bit l);
    exp_t e;
    bit due;
    due = (c == 0) ? (q0.size() > 0 && q0[0].due == edge_n) : (q1.size() > 0 && q1[0].due == edge_n);
    if (due) begin
      e = (c == 0) ? q0.pop_front() : q1.pop_front();
      chk(c == 0 ? "out_valid8" : "out_valid128", int'(v), 1);
      chk(c == 0 ? "data_r8" : "data_r128", r, e.r);
      chk(c == 0 ? "data_i8" : "data_i128", i, e.i);
      chk(c == 0 ? "first8" : "first128", int'(f), int'(e.f));
      chk(c == 0 ? "last8" : "last128", int'(l), int'(e.l));
    end else begin
      chk(c == 0 ? "idle_flags8" : "idle_flags128", int'({v, f, l}), 0);
    end
    if (v) begin
      if (log_n[c] < 256) begin
        log_r[c][log_n[c]] = r;
        log_i[c][log_n[c]] = i;
        log_f[c][log_n[c]] = f;
        log_l[c][log_n[c]] = l;
      end
      log_n[c]++;
      if (f) first_edge[c] = edge_n;
      run[c]++;
      if (run[c] > maxrun[c]) maxrun[c] = run[c];
    end else run[c] = 0;
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    pc[0] = 0;
    pc[1] = 0;
  endtask

  task automatic clear_log();
    for (int c = 0; c < 2; c++) begin
      log_n[c] = 0;
      run[c] = 0;
      maxrun[c] = 0;
      first_edge[c] = -1;
    end
  endtask

  task automatic drv8(input bit v, input int r, input int i);
    @(negedge clk);
    if8.in_valid  = v;
    if8.data_in_r = 16'(r);
    if8.data_in_i = 16'(i);
  endtask

  task automatic frame8(input int base, input bit toggle);
    for (int j = 0; j < 8; j++) begin
      drv8(1'b1, base + j, 100 + base + j);
      if (toggle) drv8(1'b0, 0, 0);
    end
  endtask

  task automatic idle8(input int n);
    repeat (n) drv8(1'b0, 0, 0);
  endtask

  task automatic chk_frame8(input string nm, input int pos, input int base);
    for (int k = 0; k < 8; k++) begin
      chk({nm, "_r"}, log_r[0][pos + k], base + PERM8[k]);
      chk({nm, "_i"}, log_i[0][pos + k], 100 + base + PERM8[k]);
    end
  endtask

  initial begin
    if8.in_valid = 1'b0;   if8.data_in_r = '0;   if8.data_in_i = '0;
    if128.in_valid = 1'b0; if128.data_in_r = '0; if128.data_in_i = '0;
    edge_n = 0; checks = 0; errors = 0;
    model_reset();
    clear_log();
    fork
      forever begin
        @(posedge clk);
        edge_n++;
        cap(0, if8.in_valid && !rst, int'(if8.data_in_r), int'(if8.data_in_i));
        cap(1, if128.in_valid && !rst, int'(if128.data_in_r), int'(if128.data_in_i));
      end
      forever begin
        @(negedge clk);
        cmp(0, if8.out_valid, int'(if8.data_out_r), int'(if8.data_out_i), if8.out_first, if8.out_last);
        cmp(1, if128.out_valid, int'(if128.data_out_r), int'(if128.data_out_i), if128.out_first, if128.out_last);
      end
    join_none

    #1 rst = 1'b1;
    #2;
    chk("reset_valid", int'(if8.out_valid), 0);
    chk("reset_flags", int'({if8.out_first, if8.out_last}), 0);
    chk("reset_data", int'({if8.data_out_r, if8.data_out_i}), 0);
    idle8(2);
    rst = 1'b0;
    idle8(2);

    clear_log();
    frame8(0, 1'b0);
    idle8(14);
    chk("single_count", log_n[0], 8);
    chk_frame8("single", 0, 0);
    chk("single_first", int'(log_f[0][0]), 1);
    chk("single_last", int'(log_l[0][7]), 1);
    chk("single_latency", first_edge[0] - last_cap[0], 2);

    clear_log();
    frame8(0, 1'b0);
    frame8(8, 1'b0);
    frame8(16, 1'b0);
    idle8(14);
    chk("b2b_count", log_n[0], 24);
    chk("b2b_run", maxrun[0], 24);
    for (int f = 0; f < 3; f++) chk_frame8("b2b", 8 * f, 8 * f);

    clear_log();
    frame8(0, 1'b1);
    idle8(14);
    chk("toggle_count", log_n[0], 8);
    chk_frame8("toggle", 0, 0);
    chk("toggle_latency", first_edge[0] - last_cap[0], 2);

    clear_log();
    for (int j = 0; j < 5; j++) drv8(1'b1, 50 + j, 150 + j);
    drv8(1'b0, 0, 0);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("rst_wr_valid", int'(if8.out_valid), 0);
    chk("rst_wr_data", int'({if8.data_out_r, if8.data_out_i}), 0);
    idle8(2);
    rst = 1'b0;
    idle8(12);
    chk("rst_wr_none", log_n[0], 0);
    frame8(0, 1'b0);
    idle8(14);
    chk("rst_wr_count", log_n[0], 8);
    chk_frame8("rst_wr", 0, 0);

    clear_log();
    frame8(32, 1'b0);
    for (int t = 0; t < 40 && log_n[0] < 3; t++) begin
      drv8(1'b0, 0, 0);
      #1;
    end
    chk("rst_rd_reached", log_n[0], 3);
    chk("rst_rd_before", int'(if8.out_valid), 1);
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_rd_valid", int'(if8.out_valid), 0);
    chk("rst_rd_data", int'({if8.data_out_r, if8.data_out_i}), 0);
    idle8(2);
    rst = 1'b0;
    idle8(14);
    chk("rst_rd_count", log_n[0], 3);
    chk("rst_rd_k2", log_r[0][2], 34);
    frame8(0, 1'b0);
    idle8(14);
    chk("rst_rd_after", log_n[0], 11);
    chk_frame8("rst_rd", 3, 0);

    clear_log();
    for (int j = 0; j < 128; j++) begin
      @(negedge clk);
      if128.in_valid  = 1'b1;
      if128.data_in_r = 16'(j);
      if128.data_in_i = 16'(100 + j);
    end
    @(negedge clk);
    if128.in_valid = 1'b0;
    repeat (140) @(negedge clk);
    chk("n128_count", log_n[1], 128);
    chk("n128_run", maxrun[1], 128);
    chk("n128_k0", log_r[1][0], 0);
    chk("n128_k1", log_r[1][1], 64);
    chk("n128_k127", log_r[1][127], 127);
    chk("n128_i1", log_i[1][1], 164);
    chk("n128_last", int'(log_l[1][127]), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
